uart_tx_sched: RTL and testbench

Round-robin transmit scheduler that shares the single transmitter of `uart_ip` between `NUM_REQ` byte requesters. It accepts one byte per valid/ready handshake, drives `start_tx`, `data_in` and `baud_tx_sel` of `uart_ip`, and waits for `tx_done` before serving the next requester. It sits between the on-chip byte sources and `uart_ip`, on the same clock.

---
 rtl/uart_tx_sched_pkg.sv | 19 +
 rtl/uart_tx_sched_if.sv | 27 ++
 rtl/uart_tx_sched_arbiter.sv | 33 +++
 rtl/uart_tx_sched.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_tx_sched scheduler.
package uart_pkg;

  localparam int BAUD_SEL_W = 3;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_RST = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester byte handshake plus the uart_ip transmit-side signals.
// slave: the scheduler. master: byte sources / uart_ip side.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [8*NUM_REQ-1:0]          req_data;
  logic [BAUD_SEL_W*NUM_REQ-1:0] req_baud;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          start_tx;
  logic [7:0]                    tx_data;
  logic [BAUD_SEL_W-1:0]         baud_tx_sel;
  logic                          tx_done;

  modport slave (
    input  req_valid, req_data, req_baud, tx_done,
    output req_ready, start_tx, tx_data, baud_tx_sel
  );

  modport master (
    output req_valid, req_data, req_baud, tx_done,
    input  req_ready, start_tx, tx_data, baud_tx_sel
  );

endinterface

// File: rtl/uart_tx_sched_arbiter.sv
// Combinational round-robin pick: first valid requester at or after i_rr_ptr.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = gid_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_idx;

  // Walk the requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (!o_any && i_req_valid[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler sharing one uart_ip transmitter between
// NUM_REQ byte requesters. Optional watchdog: UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  GAP_CYCLES     = 16,
  parameter int  TIMEOUT_CYCLES = 200000,
  localparam int GID_W          = gid_w(NUM_REQ)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             uart_en,
  uart_tx_sched_if.slave   bus,
  output logic             busy,
  output logic [GID_W-1:0] grant_id,
  output logic             tx_err,
  input  logic             err_clr
);

  localparam bit         GAP_EN   = (GAP_CYCLES > 0);
  localparam logic [7:0] GAP_LAST = GAP_EN ? 8'(GAP_CYCLES - 1) : 8'd0;

  sched_state_e          r_state, w_state_nxt;
  logic [GID_W-1:0]      r_rr_ptr;
  logic [NUM_REQ-1:0]    r_req_ready;
  logic                  r_start_tx;
  logic [7:0]            r_tx_data;
  logic [BAUD_SEL_W-1:0] r_baud;
  logic [GID_W-1:0]      r_gid;
  logic [7:0]            r_gap;

  logic [NUM_REQ-1:0]    w_grant;
  logic [GID_W-1:0]      w_gidx;
  logic                  w_any;
  logic                  w_grant_slot;
  logic                  w_grant_en;
  logic                  w_done_ok;
  logic                  w_wd_hit;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(GID_W)) u_arb (
    .i_req_valid (bus.req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_any       (w_any)
  );

  // tx_done only counts once start_tx has been presented to uart_ip.
  assign w_done_ok = (r_state == ST_BUSY) && !r_start_tx && bus.tx_done;

  // Next state; a grant may be taken on any edge that leads back to IDLE so
  // the next byte is accepted in the same cycle IDLE would have been entered.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_slot = 1'b0;
    w_grant_en   = 1'b0;
    case (r_state)
      ST_IDLE:  w_grant_slot = 1'b1;
      ST_START: w_state_nxt  = ST_BUSY;
      ST_BUSY: begin
        if (w_done_ok) begin
          if (GAP_EN) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt  = ST_IDLE;
            w_grant_slot = 1'b1;
          end
        end else if (w_wd_hit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt  = ST_IDLE;
          w_grant_slot = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!uart_en) begin
      w_state_nxt = ST_IDLE;
    end else if (w_grant_slot && w_any) begin
      w_state_nxt = ST_START;
      w_grant_en  = 1'b1;
    end
  end

  // State register, grant latch, start pulse and gap counter.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_req_ready <= '0;
      r_start_tx  <= 1'b0;
      r_tx_data   <= '0;
      r_baud      <= BAUD_SEL_RST;
      r_gid       <= '0;
      r_gap       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_grant_en ? w_grant : '0;
      r_start_tx  <= uart_en && (r_state == ST_START);
      r_gap       <= (r_state == ST_GAP && w_state_nxt == ST_GAP) ? r_gap + 8'd1 : 8'd0;
      if (w_grant_en) begin
        r_tx_data <= bus.req_data[8*int'(w_gidx) +: 8];
        r_baud    <= bus.req_baud[BAUD_SEL_W*int'(w_gidx) +: BAUD_SEL_W];
        r_gid     <= w_gidx;
        r_rr_ptr  <= (w_gidx == GID_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_tx_err;

  // A frame that never completes is abandoned; an abort via uart_en wins.
  assign w_wd_hit = uart_en && (r_state == ST_BUSY) && !r_start_tx &&
                    !bus.tx_done && (r_wd == WD_LAST);

  // Watchdog counts BUSY cycles spent waiting for tx_done.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wd <= '0;
    end else if (r_state == ST_BUSY && !r_start_tx) begin
      r_wd <= r_wd + 1'b1;
    end else begin
      r_wd <= '0;
    end
  end

  // Sticky error; a new timeout beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_tx_err <= 1'b0;
    end else if (w_wd_hit) begin
      r_tx_err <= 1'b1;
    end else if (err_clr) begin
      r_tx_err <= 1'b0;
    end
  end

  assign tx_err = r_tx_err;
`else
  logic w_unused_err_clr;

  assign w_wd_hit         = 1'b0;
  assign tx_err           = 1'b0;
  assign w_unused_err_clr = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

  assign bus.req_ready   = r_req_ready;
  assign bus.start_tx    = r_start_tx;
  assign bus.tx_data     = r_tx_data;
  assign bus.baud_tx_sel = r_baud;
  assign grant_id        = r_gid;
  assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a cycle-level reference model predicts
// each grant (cycle, requester, byte, baud) and each start_tx cycle; a monitor
// pops and compares when the DUT presents them. A second instance with
// GAP_CYCLES=0 checks back-to-back service after tx_done.
`timescale 1ns/1ps
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int G  = 16;
  localparam int TO = 50;
  localparam int GW = gid_w(N);

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] data;
    logic [2:0] baud;
  } exp_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic uart_en = 1'b1;
  logic err_clr = 1'b0;
  logic en0 = 1'b1;
  logic clr0 = 1'b0;
  logic busy, tx_err, busy0, tx_err0;
  logic [GW-1:0] grant_id, grant_id0;

  uart_tx_sched_if #(.NUM_REQ(N)) bus ();
  uart_tx_sched_if #(.NUM_REQ(N)) bus0 ();

  uart_tx_sched #(.NUM_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetn(resetn), .uart_en(uart_en), .bus(bus),
    .busy(busy), .grant_id(grant_id), .tx_err(tx_err), .err_clr(err_clr));

  uart_tx_sched #(.NUM_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut0 (
    .clock(clock), .resetn(resetn), .uart_en(en0), .bus(bus0),
    .busy(busy0), .grant_id(grant_id0), .tx_err(tx_err0), .err_clr(clr0));

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int cyc = 0;
  int mode = 0;
  bit m1_pend = 1'b0;
  int drop_s = -1;
  int done_at = -1;

  // reference model state
  int   m_ptr = 0, m_free = 0, m_d = 0;
  bit   m_wait = 1'b0, m_err = 1'b0, m_rst = 1'b0;
  exp_t gq[$];
  int   sq[$];
  int   ord[$];
  exp_t h = '{0, 0, 8'h00, 3'b111};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: what the scheduler should decide at each clock edge.
  always @(posedge clock) begin
    int e, pick;
    e = cyc;
    pick = -1;
    if (!resetn) begin
      m_ptr = 0; m_free = e + 1; m_wait = 0; m_err = 0; m_rst = 1;
      gq.delete(); sq.delete();
    end else begin
      m_rst = 0;
      if (err_clr) m_err = 0;
      if (!uart_en) begin
        if (m_wait && e == m_d + 1 && sq.size() > 0) void'(sq.pop_back());
        m_wait = 0;
        m_free = e + 1;
      end else begin
        if (m_wait && e >= m_d + 3) begin
          if (bus.tx_done) begin
            m_wait = 0;
            m_free = e + G;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          else if (e == m_d + 2 + TO) begin
            m_wait = 0;
            m_err  = 1;
            m_free = e + 1;
          end
`endif
        end
        if (!m_wait && e >= m_free) begin
          for (int k = 0; k < N; k++)
            if (pick < 0 && bus.req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
          if (pick >= 0) begin
            gq.push_back('{e + 1, pick, bus.req_data[8*pick +: 8], bus.req_baud[3*pick +: 3]});
            sq.push_back(e + 2);
            m_ptr  = (pick + 1) % N;
            m_d    = e;
            m_wait = 1;
            m_free = 1 << 30;
          end
        end
      end
    end
    cyc = e + 1;
  end

  // Monitor: compares DUT outputs with the scoreboard queues.
  always @(negedge clock) begin
    exp_t x;
    if (m_rst) begin
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_start_tx", bus.start_tx, 0);
      check("rst_baud", bus.baud_tx_sel, 3'b111);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_tx_err", tx_err, 0);
      h = '{0, 0, 8'h00, 3'b111};
    end else begin
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        check("grant_missing", cyc, gq[0].cyc);
        void'(gq.pop_front());
      end
      if (bus.req_ready != 0) begin
        if (gq.size() == 0) begin
          check("grant_unexpected", bus.req_ready, 0);
        end else begin
          x = gq.pop_front();
          check("grant_cycle", cyc, x.cyc);
          check("grant_onehot", bus.req_ready, 1 << x.id);
          check("grant_id", grant_id, x.id);
          check("grant_tx_data", bus.tx_data, x.data);
          check("grant_baud", bus.baud_tx_sel, x.baud);
          if (mode == 2) ord.push_back(x.id);
          h = x;
        end
      end else begin
        check("hold_regs", {grant_id, bus.baud_tx_sel, bus.tx_data},
              {h.id[GW-1:0], h.baud, h.data});
      end
      while (sq.size() > 0 && sq[0] < cyc) begin
        check("start_missing", cyc, sq[0]);
        void'(sq.pop_front());
      end
      if (bus.start_tx) begin
        if (sq.size() == 0) check("start_unexpected", bus.start_tx, 0);
        else check("start_cycle", cyc, sq.pop_front());
        check("busy_at_start", busy, 1);
      end
      check("tx_err", tx_err, m_err);
    end
  end

  // Stimulus driver and uart_ip frame model for the main instance.
  always @(negedge clock) begin
    resetn  = (mode != 0);
    err_clr = 1'b0;
    uart_en = 1'b1;
    if (mode == 1 && bus.req_ready[0]) m1_pend = 1'b0;
    if (mode == 3 && bus.start_tx && drop_s < 0) drop_s = cyc + 10;
    case (mode)
      0: begin
        bus.req_valid = '1;
        bus.req_data  = $urandom;
        bus.req_baud  = 12'($urandom);
      end
      1: begin
        bus.req_valid     = m1_pend ? 4'b0001 : 4'b0000;
        bus.req_data[7:0] = 8'h5A;
        bus.req_baud[2:0] = 3'b111;
      end
      2, 3: begin
        bus.req_valid = '1;
        bus.req_data  = 32'h1312_1110;
        bus.req_baud  = {3'd3, 3'd2, 3'd1, 3'd0};
        if (mode == 3 && drop_s >= 0 && cyc >= drop_s && cyc < drop_s + 5) uart_en = 1'b0;
      end
      4: begin
        for (int i = 0; i < N; i++)
          if (bus.req_ready[i] || $urandom_range(7) == 0) begin
            bus.req_valid[i]       = 1'($urandom);
            bus.req_data[8*i +: 8] = 8'($urandom);
            bus.req_baud[3*i +: 3] = 3'($urandom);
          end
        uart_en = ($urandom_range(299) != 0);
        err_clr = ($urandom_range(49) == 0);
      end
      default: bus.req_valid = '0;
    endcase
    if (!resetn) begin
      done_at = -1;
    end else if (bus.start_tx) begin
      if (mode == 1) done_at = cyc + 100;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      else if (mode == 4 && $urandom_range(3) == 0) done_at = -1;
`endif
      else done_at = cyc + 20 + $urandom_range(40);
    end
    if (!uart_en) done_at = -1;
    bus.tx_done = resetn && (cyc == done_at);
  end

  // GAP_CYCLES=0 instance: requester 2 always valid, served the cycle after tx_done.
  int   d0_at = -1, last_done0 = -1, g0_n = 0;
  logic [7:0] data0 = 8'h00, exp0 = 8'h00;
  always @(negedge clock) begin
    bus0.req_valid = 4'b0100;
    bus0.req_baud  = '0;
    if (!resetn) begin
      d0_at = -1;
      last_done0 = -1;
    end else begin
      if (bus0.req_ready != 0) begin
        check("g0_onehot", bus0.req_ready, 4'b0100);
        if (last_done0 >= 0) check("g0_after_done", cyc, last_done0 + 1);
        g0_n++;
        exp0  = data0;
        data0 = 8'($urandom);
      end
      if (bus0.start_tx) begin
        check("g0_tx_data", bus0.tx_data, exp0);
        d0_at = cyc + 20 + $urandom_range(9);
      end
    end
    bus0.req_data = {8'h00, data0, 16'h0000};
    bus0.tx_done  = resetn && (cyc == d0_at);
    if (bus0.tx_done) last_done0 = cyc;
  end

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.req_baud = '0; bus.tx_done = 1'b0;
    bus0.req_valid = '0; bus0.req_data = '0; bus0.req_baud = '0; bus0.tx_done = 1'b0;
    mode = 0;
    repeat (10) @(posedge clock);
    m1_pend = 1'b1;
    mode = 1;
    repeat (300) @(posedge clock);
    mode = 0;
    repeat (3) @(posedge clock);
    mode = 2;
    repeat (450) @(posedge clock);
    for (int k = 0; k < 5; k++)
      check("rr_order", (ord.size() > k) ? ord[k] : -1, k % 4);
    drop_s = -1;
    mode = 3;
    repeat (300) @(posedge clock);
    mode = 4;
    repeat (5000) @(posedge clock);
    mode = 5;
    repeat (400) @(posedge clock);
    check("grant_queue_drained", gq.size(), 0);
    check("start_queue_drained", sq.size(), 0);
    check("g0_served", g0_n > 20, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
